mips_alu_mc: RTL
================

MIPS_ALU_MC -- requirements
Module: mips_alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; legal values 8..64.
REQ-002 SHALL have input clock, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have input reset, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have input start, 1 bit: operation request, sampled when not busy.
REQ-005 SHALL have input ALUctl, 4 bits: operation code.
REQ-006 SHALL have inputs A and B, WIDTH bits each: operands.
REQ-007 SHALL have output ALUOut, WIDTH bits: registered result.
REQ-008 SHALL have output Zero, 1 bit: high when ALUOut equals 0.
REQ-009 SHALL have output Overflow, 1 bit: registered signed overflow of ADD/SUB.
REQ-010 SHALL have outputs busy and done, 1 bit each: busy = operation in progress; done = one-cycle completion pulse.

Function
REQ-011 ALUctl codes SHALL be: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT signed, 5 NOR, 6 XOR, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MUL, 12 DIVU, 13 REMU; 14-15 give result 0.
REQ-012 Shifts SHALL shift B by A[clog2(WIDTH)-1:0]; the upper bits of A are ignored.
REQ-013 SLT/SLTU SHALL give 1 or 0, zero-extended to WIDTH.
REQ-014 ADD/SUB SHALL wrap modulo 2^WIDTH; Overflow SHALL be set on signed overflow for ADD/SUB only and cleared for all other ops.
REQ-015 MUL SHALL return the low WIDTH bits of unsigned A*B, using one shift-add step per cycle.
REQ-016 DIVU/REMU SHALL return the unsigned quotient/remainder, using one restoring-division step per cycle.
REQ-017 When B==0, DIVU SHALL return all ones and REMU SHALL return A, with no exception signal.
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
REQ-019 In IDLE or DONE, start SHALL latch A, B and ALUctl.
REQ-020 From IDLE or DONE with start high, ops 0-10 and 14-15 SHALL go to DONE, with ALUOut valid at the next edge (latency 1).
REQ-021 From IDLE or DONE with start high, ops 11-13 SHALL go to RUN.
REQ-022 RUN SHALL last exactly WIDTH cycles, counted by an iteration counter, then go to DONE (latency WIDTH+1).
REQ-023 DONE SHALL last one cycle and assert done=1; it SHALL go to IDLE if start is low.
REQ-024 busy SHALL equal (state==RUN).
REQ-025 start SHALL be ignored while busy; A, B and ALUctl changes during RUN SHALL NOT affect the result.
REQ-026 ALUOut, Zero and Overflow SHALL update only on entry to DONE and hold between operations.
REQ-027 start in DONE SHALL be accepted (back-to-back); done SHALL pulse once per accepted start.

Reset
REQ-028 With reset high at a rising edge: state=IDLE, counter=0, ALUOut=0, Zero=1, Overflow=0, busy=0, done=0.
REQ-029 Reset SHALL take priority over start.
REQ-030 Reset during RUN SHALL abort the operation with no done pulse and leave ALUOut=0.

Structure
REQ-031 Package mips_alu_pkg SHALL hold the ALUctl op encodings, the state enum, and the is_multicycle(op) function.
REQ-032 Sub-module mips_alu_iter SHALL hold the shared shift-add/restoring-divide datapath: accumulator, partial-remainder and operand shift registers, stepped by an enable.
REQ-033 Single-cycle ops SHALL be combinational logic in mips_alu_mc ahead of the result register.

Verification (WIDTH=32)
REQ-034 ADD 0x7FFFFFFF+1, start 1 cycle -> done next cycle, ALUOut=0x80000000, Overflow=1, Zero=0.
REQ-035 SUB 5-5 -> ALUOut=0, Zero=1, Overflow=0; SRA with A=4, B=0x80000000 -> 0xF8000000.
REQ-036 MUL 0x10000*0x10001 -> busy for 32 cycles, done at cycle 33, ALUOut=0x00010000; start pulsed mid-RUN is ignored.
REQ-037 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
REQ-038 Back-to-back: AND issued in DONE of a DIVU -> done high two consecutive cycles, ALUOut updated each cycle.
REQ-039 Reset asserted at RUN cycle 10 of a MUL -> next cycle IDLE, ALUOut=0, no done; a following OR 0xF0|0x0F -> 0xFF.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared definitions for the multi-cycle MIPS ALU: op encodings, FSM states
// and the op classifier used by both the RTL and anything binding to it.
package mips_alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mips_alu_iter.sv
// Shared iterative datapath: shift-add multiply and restoring unsigned divide.
// The *_next outputs are the values the registers take on the current step.
module mips_alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] prod_next,
  output logic [WIDTH-1:0] quot_next,
  output logic [WIDTH-1:0] rem_next
);

  // acc: product accumulator / partial remainder
  // sa:  multiplicand (shifts left) / dividend-then-quotient (shifts left)
  // sb:  multiplier (shifts right) / divisor (static)
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;

  logic [WIDTH:0]   rem_shift;
  logic             fits;

  assign prod_next = sb[0] ? acc + sa : acc;

  // With a zero divisor every trial subtraction fits, which naturally yields
  // an all-ones quotient and a remainder equal to the dividend.
  assign rem_shift = {acc, sa[WIDTH-1]};
  assign fits      = rem_shift >= {1'b0, sb};
  assign rem_next  = fits ? WIDTH'(rem_shift - {1'b0, sb}) : rem_shift[WIDTH-1:0];
  assign quot_next = {sa[WIDTH-2:0], fits};

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
      sa  <= '0;
      sb  <= '0;
    end else if (load) begin
      acc <= '0;
      sa  <= a;
      sb  <= b;
    end else if (step) begin
      if (is_div) begin
        acc <= rem_next;
        sa  <= quot_next;
      end else begin
        acc <= prod_next;
        sa  <= {sa[WIDTH-2:0], 1'b0};
        sb  <= {1'b0, sb[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mips_alu_mc.sv
// Multi-cycle MIPS ALU: single-cycle ops complete in one edge, MUL/DIVU/REMU
// iterate WIDTH cycles. Handshake: start is taken whenever busy is low; done
// pulses for exactly one cycle per accepted start, with ALUOut valid alongside.
module mips_alu_mc
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             busy,
  output logic             done,
  output state_t           state_dbg
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ov;
  logic [WIDTH-1:0] mc_res;
  logic [WIDTH-1:0] prod_next;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] rem_next;
  logic             accept;

  assign accept    = start && (state != ST_RUN);
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign Zero      = (ALUOut == '0);
  assign state_dbg = state;

  assign shamt = A[SW-1:0];
  assign sum   = A + B;
  assign dif   = A - B;

  always_comb begin
    sc_res = '0;
    sc_ov  = 1'b0;
    case (ALUctl)
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_ADD: begin
        sc_res = sum;
        sc_ov  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif;
        sc_ov  = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  sc_res[0] = $signed(A) < $signed(B);
      OP_NOR:  sc_res = ~(A | B);
      OP_XOR:  sc_res = A ^ B;
      OP_SLTU: sc_res[0] = A < B;
      OP_SLL:  sc_res = B << shamt;
      OP_SRL:  sc_res = B >> shamt;
      OP_SRA:  sc_res = $signed(B) >>> shamt;
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    mc_res = rem_next;
    if (op_q == OP_MUL)       mc_res = prod_next;
    else if (op_q == OP_DIVU) mc_res = quot_next;
  end

  mips_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clock     (clock),
    .reset     (reset),
    .load      (accept && is_multicycle(ALUctl)),
    .step      (state == ST_RUN),
    .is_div    (op_q != OP_MUL),
    .a         (A),
    .b         (B),
    .prod_next (prod_next),
    .quot_next (quot_next),
    .rem_next  (rem_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      ALUOut   <= '0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_q <= ALUctl;
            if (is_multicycle(ALUctl)) begin
              state <= ST_RUN;
              cnt   <= '0;
            end else begin
              state    <= ST_DONE;
              ALUOut   <= sc_res;
              Overflow <= sc_ov;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // The final step's result is captured straight from the step logic.
          if (cnt == CW'(WIDTH - 1)) begin
            state    <= ST_DONE;
            ALUOut   <= mc_res;
            Overflow <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
